// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with valid/ready start and result handshakes; one full_adder cell, LSB first.
// Optional macro SERIAL_SUB_EN adds port sub (a + ~b + 1 when set at accept).

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic             r_start_ready;
  logic             r_busy;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;
  logic             w_s;
  logic             w_co;

`ifdef SERIAL_SUB_EN
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub | cin;
`else
  assign w_b_in = b;
  assign w_c_in = cin;
`endif

  full_adder u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_co)
  );

  // r_a doubles as the result register: sum bits enter at the MSB as operand bits leave the LSB.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_carry       <= 1'b0;
      r_cnt         <= '0;
      r_sum         <= '0;
      r_cout        <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a           <= a;
            r_b           <= w_b_in;
            r_carry       <= w_c_in;
            r_cnt         <= '0;
            r_state       <= RUN;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        RUN: begin
          r_a     <= {w_s, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_co;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            r_sum       <= {w_s, r_a[WIDTH-1:1]};
            r_cout      <= w_co;
            r_ovf       <= r_carry ^ w_co;
            r_state     <= DONE;
            r_res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state       <= IDLE;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign busy        = r_busy;
  assign res_valid   = r_res_valid;
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=32): vector table, scoreboard queue,
// back-pressure and mid-operation reset sequences.

module tb_serial_add_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
`ifdef SERIAL_SUB_EN
    .sub         (sub),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    exp_t         e;
    logic [W:0]   t;
    logic [W-1:0] yy;
    logic         cc;
    yy     = s ? ~y : y;
    cc     = s ? 1'b1 : c;
    t      = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s, input exp_t e);
    for (int i = 0; i < 100 && !start_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check("start_ready_wait", start_ready, 1'b1);
    a = x; b = y; cin = c; sub = s;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a   = $urandom;
    b   = $urandom;
    cin = ~cin;
    sub = ~sub;
    sb.push_back(e);
  endtask

  task automatic wait_result();
    int           edges;
    int           changed;
    int           busy_lo;
    logic [W-1:0] held;
    edges = 0; changed = 0; busy_lo = 0;
    held  = sum;
    check("busy_after_accept", busy, 1'b1);
    while (!res_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (!res_valid && sum !== held) changed++;
      if (!busy) busy_lo++;
    end
    check("latency_edges", edges, W);
    check("sum_held_in_run", changed, 0);
    check("busy_low_in_run", busy_lo, 0);
  endtask

  task automatic finish_result();
    exp_t e;
    check("scoreboard_nonempty", sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("res_valid", res_valid, 1'b1);
      check("sum", sum, e.sum);
      check("cout", cout, e.cout);
      check("ovf", ovf, e.ovf);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("res_valid_after_hs", res_valid, 1'b0);
    check("start_ready_after_hs", start_ready, 1'b1);
    check("busy_after_hs", busy, 1'b0);
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s, input exp_t e);
    start_op(x, y, c, s, e);
    wait_result();
    finish_result();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [W-1:0] x, y;
    logic         c;

    vecs.push_back('{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1});
    vecs.push_back('{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
`ifdef SERIAL_SUB_EN
    vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_start_ready", start_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);

    // IDLE without accept holds
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold_ready", start_ready, 1'b1);
    check("idle_hold_busy", busy, 1'b0);

    foreach (vecs[i]) begin
      e.sum = vecs[i].sum; e.cout = vecs[i].cout; e.ovf = vecs[i].ovf;
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, e);
    end

    for (int i = 0; i < 6; i++) begin
      x = $urandom; y = $urandom; c = 1'($urandom);
      do_op(x, y, c, 1'b0, model(x, y, c, 1'b0));
    end

    // Back-pressure: result held, new start refused until after the handshake
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0));
    wait_result();
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      check("bp_res_valid", res_valid, 1'b1);
      check("bp_start_ready", start_ready, 1'b0);
      check("bp_sum", sum, 32'h8000_0000);
      check("bp_cout", cout, 1'b0);
      check("bp_ovf", ovf, 1'b1);
    end
    a = 32'd10; b = 32'd20; cin = 1'b0; sub = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    void'(sb.pop_front());
    check("bp_idle_ready", start_ready, 1'b1);
    check("bp_idle_busy", busy, 1'b0);
    sb.push_back(model(32'd10, 32'd20, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = $urandom; b = $urandom;
    check("bp_accept_busy", busy, 1'b1);
    check("bp_accept_ready", start_ready, 1'b0);
    wait_result();
    finish_result();

    // Reset mid-operation at bit 10
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b1; sub = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("midrun_busy", busy, 1'b1);
    rst = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    res_ready = 1'b0;
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_sum", sum, '0);
    check("mid_rst_start_ready", start_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    e.sum = 32'h0000_0008; e.cout = 1'b0; e.ovf = 1'b0;
    do_op(32'd3, 32'd4, 1'b1, 1'b0, e);

    // Reset while in DONE wins over the result handshake
    start_op(32'd1, 32'd1, 1'b0, 1'b0, model(32'd1, 32'd1, 1'b0, 1'b0));
    wait_result();
    void'(sb.pop_front());
    rst = 1'b1;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_valid = 1'b0;
    check("done_rst_res_valid", res_valid, 1'b0);
    check("done_rst_sum", sum, '0);
    check("done_rst_busy", busy, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start_valid, input, 1 bit: the requester presents an operation.
REQ-005 The block SHALL have port start_ready, output, 1 bit: the block can accept an operation.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-007 The block SHALL have port cin, input, 1 bit: the carry-in.
REQ-008 The block SHALL have port sub, input, 1 bit, present only when SERIAL_SUB_EN is defined: selects subtract.
REQ-009 The block SHALL have port res_valid, output, 1 bit: the result is available.
REQ-010 The block SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-012 The block SHALL have port cout, output, 1 bit: the final carry out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1 bit: signed overflow.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL contain exactly one instance of the team's 1-bit full_adder cell and compute the sum bit-serially, LSB first, one bit per cycle.
REQ-016 The FSM SHALL have states IDLE, RUN and DONE, and start_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, an accept (start_valid and start_ready high at a rising edge) SHALL capture a, b, cin (and sub) into internal shift/carry registers, clear the bit counter, and go to RUN.
REQ-018 In IDLE with no accept, the state and all outputs SHALL hold.
REQ-019 In RUN, each edge SHALL feed the current LSBs and the carry register to the cell, shift the sum bit into the MSB of the result register, shift the operands right, register the cell carry, and increment the counter.
REQ-020 The block SHALL go from RUN to DONE on the edge that processes bit WIDTH-1, so res_valid is high after exactly WIDTH rising edges following the accept edge.
REQ-021 cout SHALL equal the carry out of bit WIDTH-1.
REQ-022 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-023 In DONE, res_valid SHALL be 1, and sum, cout and ovf SHALL be held stable until res_valid and res_ready are both high at an edge; the block then returns to IDLE.
REQ-024 sum, cout and ovf SHALL retain their last result in IDLE and RUN and SHALL change only on the RUN-to-DONE edge.
REQ-025 A start_valid asserted while in DONE, including in the same cycle as res_ready, SHALL NOT be accepted; it SHALL be accepted at the earliest on the cycle after the return to IDLE.
REQ-026 Changes to a, b, cin or sub after the accept edge SHALL NOT affect the result.

Reset
REQ-027 When rst is high at an edge, including mid-RUN or in DONE, the block SHALL abort any operation and enter IDLE.
REQ-028 Reset SHALL set res_valid=0, busy=0, sum=0, cout=0 and ovf=0, and clear the counter and shift/carry registers; start_ready SHALL be 1 after reset.
REQ-029 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-030 Macro SERIAL_SUB_EN, when defined, SHALL add port sub; with sub=1 at accept, the block SHALL compute a + ~b + 1 and ignore cin.
REQ-031 Without SERIAL_SUB_EN, port sub and all inversion logic SHALL be absent, and the block SHALL always compute a + b + cin.

Verification (WIDTH=32)
REQ-032 Add with wrap: a=0x00000001, b=0xFFFFFFFF, cin=0 -> sum=0x00000000, cout=1, ovf=0, res_valid high exactly 32 edges after accept.
REQ-033 Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1; busy=1 throughout RUN and DONE.
REQ-034 Back-pressure: hold res_ready=0 for 5 cycles after res_valid while driving start_valid=1 and changing a/b -> sum, cout, ovf and res_valid are stable, start_ready=0, and the new start is accepted the cycle after the res handshake.
REQ-035 Reset mid-operation: assert rst at bit 10 of RUN -> next cycle IDLE, res_valid=0, sum=0, start_ready=1; a following 3+4 (cin=1) gives sum=0x00000008.
REQ-036 With SERIAL_SUB_EN: sub=1, a=5, b=7, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; sub=1, a=7, b=5 -> sum=0x00000002, cout=1.
